rb_reader: RTL and testbench
============================

// Module: rb_reader
// PURPOSE
//   Read-back engine for the result RAM filled by the write-back stage: fetches a burst of
//   BURST result words from consecutive addresses and streams them out on valid/ready.
//   Sits between the shared result RAM read port and the downstream consumer (host/output
//   interface). Tolerates fixed RAM read latency and consumer back-pressure without losing
//   or duplicating words.
// PARAMETERS
//   ADDR_W   8   RAM address width; address arithmetic wraps modulo 2**ADDR_W
//   DATA_W   32  RAM word width
//   RES_W    17  result width; out_data = ram_rdata[RES_W-1:0]
//   BURST    4   words per read-back request (>=1)
//   RAM_LAT  1   cycles from ram_en high to ram_rdata valid (1..3)
// PORTS
//   clk         in   1        clock, rising edge
//   rst         in   1        reset, asynchronous, active-low
//   start       in   1        request pulse; sampled only in IDLE
//   start_addr  in   ADDR_W   first RAM address of the burst, captured with start
//   ram_en      out  1        RAM read enable, one read per cycle high
//   ram_addr    out  ADDR_W   RAM read address, valid while ram_en=1
//   ram_rdata   in   DATA_W   RAM read data, valid RAM_LAT cycles after ram_en
//   out_data    out  RES_W    result word to consumer
//   out_valid   out  1        out_data valid
//   out_ready   in   1        consumer accepts when out_valid & out_ready
//   busy        out  1        high from cycle after accepted start until done
//   done        out  1        one-cycle pulse after last word handed over
// BEHAVIOUR
//   - Reset (rst=0): ram_en=0, ram_addr=0, out_data=0, out_valid=0, busy=0, done=0; FIFO
//     empty, counters 0, in-flight reads discarded. Reset mid-burst aborts it; no done.
//   - FSM: IDLE -> READ on start=1 (latch start_addr, issue_cnt=0, recv_cnt=0);
//     READ -> DRAIN when issue_cnt reaches BURST; DRAIN -> DONE when recv_cnt=BURST and
//     FIFO empty; DONE -> IDLE unconditionally (done=1 for exactly this cycle).
//   - start while busy or in DONE is ignored (no queueing).
//   - Issue: in READ, ram_en=1 iff fifo_count + inflight < BURST (credit rule); each issue
//     uses ram_addr = start_addr + issue_cnt (mod 2**ADDR_W), then issue_cnt++.
//     Back-to-back issue when credits allow: BURST reads in BURST consecutive cycles.
//   - Capture: a RAM_LAT-deep valid shift register tracks in-flight reads; when its tail is
//     1, ram_rdata[RES_W-1:0] is pushed into FIFO (depth BURST), recv_cnt++. Credit rule
//     guarantees the FIFO never overflows; overflow is an assertion failure.
//   - Output: out_valid = FIFO non-empty; out_data = FIFO head (registered, first-word
//     fall-through). Pop on out_valid & out_ready. out_data/out_valid hold stable while
//     out_valid=1 and out_ready=0.
//   - Simultaneous push and pop in one cycle: count unchanged, both take effect.
//   - Latency, out_ready tied 1: first out_valid RAM_LAT+1 cycles after start sampled;
//     done RAM_LAT+BURST+2 cycles after start.
//   - busy = (state != IDLE) & (state != DONE).
// STRUCTURE
//   - Shared package rb_pkg: FSM encoding (RB_IDLE, RB_READ, RB_DRAIN, RB_DONE), default
//     ADDR_W/DATA_W/RES_W/BURST constants shared with the write-back stage.
//   - Sub-module rb_fifo: synchronous FIFO, params WIDTH/DEPTH, ports push/pop/din/dout/
//     count/empty/full, async active-low reset. Top holds FSM, counters, latency pipe.
// TESTING
//   1 Preload RAM[0..3]=0x00000011,0x00000022,0x0001FFFF,0xFFFE0005; start, start_addr=0,
//     out_ready=1 -> out_data 0x11,0x22,0x1FFFF,0x00005 in order, done at cycle 7 (LAT=1).
//   2 start_addr=0xFE, BURST=4 -> ram_addr sequence 0xFE,0xFF,0x00,0x01 (wrap).
//   3 out_ready=0 for 10 cycles after start -> exactly 4 reads issued, ram_en then 0,
//     out_data=first word held stable; release -> 4 words, no loss/duplication.
//   4 out_ready toggling 1010... -> output order preserved, done only after 4th accept.
//   5 second start pulse during READ -> ignored; exactly 4 words, one done pulse.
//   6 rst asserted after 2 words delivered -> all outputs to reset values immediately;
//     after release and new start_addr=8, 4 fresh words from RAM[8..11], no stale data.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared definitions for the result read-back path: FSM encoding and the default
// geometry constants the write-back stage also uses.
package rb_pkg;
  localparam int RB_ADDR_W  = 8;
  localparam int RB_DATA_W  = 32;
  localparam int RB_RES_W   = 17;
  localparam int RB_BURST   = 4;
  localparam int RB_RAM_LAT = 1;

  typedef enum logic [1:0] {
    RB_IDLE  = 2'd0,
    RB_READ  = 2'd1,
    RB_DRAIN = 2'd2,
    RB_DONE  = 2'd3
  } rb_state_t;
endpackage

// File: rtl/rb_fifo.sv
// Small synchronous FIFO with first-word fall-through: dout always shows the head entry.
// A push into a full FIFO is only legal together with a pop in the same cycle.
module rb_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
endmodule

// File: rtl/rb_reader.sv
// Burst read-back engine: issues BURST consecutive RAM reads under a credit limit, absorbs
// the fixed read latency into a FIFO and streams results out on valid/ready.
module rb_reader
  import rb_pkg::*;
#(
  parameter int ADDR_W  = RB_ADDR_W,
  parameter int DATA_W  = RB_DATA_W,
  parameter int RES_W   = RB_RES_W,
  parameter int BURST   = RB_BURST,
  parameter int RAM_LAT = RB_RAM_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [RES_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done,
  output logic [1:0]        fsm_state
);
  localparam int CW = $clog2(BURST + 1);
  localparam int SW = CW + 2;

  rb_state_t         state;
  rb_state_t         state_nxt;
  logic [ADDR_W-1:0] base;
  logic [CW-1:0]     issue_cnt;
  logic [CW-1:0]     recv_cnt;
  logic [CW-1:0]     fifo_count;
  logic [RAM_LAT-1:0] pipe;
  logic [SW-1:0]     inflight;
  logic [SW-1:0]     credit_sum;
  logic [RES_W-1:0]  fifo_dout;
  logic              tail;
  logic              fifo_empty;
  logic              fifo_full_unused;
  logic              pop;

  generate
    if (DATA_W > RES_W) begin : g_unused_hi
      logic unused_rdata_hi;
      assign unused_rdata_hi = ^ram_rdata[DATA_W-1:RES_W];
    end
  endgenerate

  // Reads already in the RAM pipeline count against FIFO space, so a stalled consumer
  // can never cause an overflow.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RAM_LAT; i++) inflight = inflight + SW'(pipe[i]);
  end

  assign tail       = pipe[RAM_LAT-1];
  assign credit_sum = SW'(fifo_count) + inflight;
  assign ram_en     = (state == RB_READ) && (issue_cnt != CW'(BURST)) &&
                      (credit_sum < SW'(BURST));
  assign ram_addr   = ram_en ? base + ADDR_W'(issue_cnt) : '0;

  assign out_valid  = ~fifo_empty;
  assign out_data   = out_valid ? fifo_dout : '0;
  assign pop        = out_valid & out_ready;
  assign busy       = (state == RB_READ) || (state == RB_DRAIN);
  assign done       = (state == RB_DONE);
  assign fsm_state  = state;

  always_comb begin
    state_nxt = state;
    case (state)
      RB_IDLE:  if (start) state_nxt = RB_READ;
      RB_READ:  if (issue_cnt == CW'(BURST)) state_nxt = RB_DRAIN;
      RB_DRAIN: if (recv_cnt == CW'(BURST) && fifo_empty) state_nxt = RB_DONE;
      RB_DONE:  state_nxt = RB_IDLE;
      default:  state_nxt = RB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= RB_IDLE;
      base      <= '0;
      issue_cnt <= '0;
      recv_cnt  <= '0;
      pipe      <= '0;
    end else begin
      state <= state_nxt;
      pipe  <= (pipe << 1) | RAM_LAT'(ram_en);
      if (state == RB_IDLE && start) begin
        base      <= start_addr;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end else begin
        if (ram_en) issue_cnt <= issue_cnt + CW'(1);
        if (tail)   recv_cnt  <= recv_cnt + CW'(1);
      end
    end
  end

  rb_fifo #(
    .WIDTH(RES_W),
    .DEPTH(BURST)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (tail),
    .pop  (pop),
    .din  (ram_rdata[RES_W-1:0]),
    .dout (fifo_dout),
    .count(fifo_count),
    .empty(fifo_empty),
    .full (fifo_full_unused)
  );
endmodule

// File: tb/tb_rb_reader.sv
// Bench for rb_reader: behavioural RAM with one-cycle latency, table of bursts with
// different consumer patterns, scoreboard of expected words and addresses, reset abort.
module tb_rb_reader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int RES_W  = 17;
  localparam int BURST  = 4;

  localparam int M_READY  = 0;
  localparam int M_TOGGLE = 1;
  localparam int M_RANDOM = 2;
  localparam int M_STALL  = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [ADDR_W-1:0] start_addr;
  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic [RES_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;
  logic [1:0]        fsm_state;

  logic [DATA_W-1:0] ram_mem [256];
  logic [RES_W-1:0]  exp_q[$];
  logic [ADDR_W-1:0] addr_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int en_cnt   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  logic              prev_stall;
  logic [RES_W-1:0]  prev_data;

  typedef struct {
    logic [7:0] addr;
    int         mode;
    int         exp_first;
    int         exp_done;
    bit         dup_start;
  } tc_t;
  tc_t tbl [6];

  rb_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .start_addr(start_addr),
    .ram_en    (ram_en),
    .ram_addr  (ram_addr),
    .ram_rdata (ram_rdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done),
    .fsm_state (fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAM, read latency 1
  always @(posedge clk) begin
    if (ram_en) ram_rdata <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      prev_stall = 1'b0;
    end else begin
      if (ram_en) begin
        en_cnt++;
        n_checks++;
        if (addr_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_read: got addr 0x%0h expected no read", ram_addr);
        end else begin
          chk("ram_addr", 32'(ram_addr), 32'(addr_q.pop_front()));
        end
      end
      if (prev_stall) begin
        chk("hold_valid", 32'(out_valid), 32'd1);
        chk("hold_data", 32'(out_data), 32'(prev_data));
      end
      if (out_valid && out_ready) begin
        acc_cnt++;
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL extra_word: got 0x%0h expected no word", out_data);
        end else begin
          chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_after_last_word", exp_q.size(), 0);
      end
      prev_stall = out_valid & ~out_ready;
      prev_data  = out_data;
    end
  end

  function automatic logic ready_for(input int mode, input int cyc);
    case (mode)
      M_TOGGLE: return (cyc % 2) == 0;
      M_RANDOM: return 1'($urandom_range(0, 1));
      M_STALL:  return cyc >= 10;
      default:  return 1'b1;
    endcase
  endfunction

  // driver: one burst from start pulse to done, then idle checks
  task automatic run_burst(input logic [7:0] addr, input int mode, input int exp_first,
                           input int exp_done, input bit dup_start);
    int cyc, first_cyc, done_cyc, en0, dn0;
    logic [7:0] a;
    en0 = en_cnt;
    dn0 = done_cnt;
    first_cyc = -1;
    done_cyc = -1;
    for (int i = 0; i < BURST; i++) begin
      a = addr + 8'(i);
      addr_q.push_back(a);
      exp_q.push_back(ram_mem[a][RES_W-1:0]);
    end
    start = 1'b1;
    start_addr = addr;
    out_ready = ready_for(mode, 0);
    @(posedge clk); #1;
    start = 1'b0;
    start_addr = 8'h99;
    cyc = 0;
    while (done_cyc < 0 && cyc < 100) begin
      out_ready = ready_for(mode, cyc);
      start = dup_start && (cyc == 1 || cyc == 3);
      @(negedge clk);
      if (cyc == 0) chk("busy_after_start", 32'(busy), 32'd1);
      if (out_valid && first_cyc < 0) first_cyc = cyc;
      if (done) done_cyc = cyc;
      if (mode == M_STALL && cyc == 9) begin
        chk("stall_reads_issued", en_cnt - en0, BURST);
        chk("stall_ram_en_low", 32'(ram_en), 32'd0);
        chk("stall_valid", 32'(out_valid), 32'd1);
        if (exp_q.size() > 0) chk("stall_head", 32'(out_data), 32'(exp_q[0]));
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done_cyc >= 0), 32'd1);
    if (exp_first >= 0) chk("first_valid_latency", first_cyc, exp_first);
    if (exp_done >= 0) chk("done_latency", done_cyc, exp_done);
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("done_pulses", done_cnt - dn0, 1);
    chk("reads_issued", en_cnt - en0, BURST);
    chk("words_left", exp_q.size(), 0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_state", 32'(fsm_state), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ram_en"}, 32'(ram_en), 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
    chk({tag, "_out_data"}, 32'(out_data), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, acc0, dn0;
    rst = 1'b0;
    start = 1'b0;
    start_addr = '0;
    out_ready = 1'b0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int i = 0; i < 256; i++) ram_mem[i] = $urandom;
    ram_mem[0] = 32'h0000_0011;
    ram_mem[1] = 32'h0000_0022;
    ram_mem[2] = 32'h0001_FFFF;
    ram_mem[3] = 32'hFFFE_0005;

    tbl[0] = '{8'h00, M_READY,  2,  7, 1'b0};
    tbl[1] = '{8'hFE, M_READY,  2,  7, 1'b0};
    tbl[2] = '{8'h30, M_STALL,  -1, 15, 1'b0};
    tbl[3] = '{8'h50, M_TOGGLE, 2,  10, 1'b0};
    tbl[4] = '{8'h70, M_READY,  2,  7, 1'b1};
    tbl[5] = '{8'hC0, M_RANDOM, 2,  -1, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    chk("reset_state", 32'(fsm_state), 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;

    for (int t = 0; t < 6; t++)
      run_burst(tbl[t].addr, tbl[t].mode, tbl[t].exp_first, tbl[t].exp_done, tbl[t].dup_start);

    // reset in the middle of a burst after two words were handed over
    acc0 = acc_cnt;
    dn0 = done_cnt;
    for (int i = 0; i < BURST; i++) begin
      addr_q.push_back(8'h20 + 8'(i));
      exp_q.push_back(ram_mem[8'h20 + i][RES_W-1:0]);
    end
    start = 1'b1;
    start_addr = 8'h20;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (acc_cnt - acc0 < 2 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("pre_reset_accepts", acc_cnt - acc0, 2);
    rst = 1'b0;
    exp_q.delete();
    addr_q.delete();
    #1;
    chk_reset_outputs("abort");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("no_done_on_abort", done_cnt - dn0, 0);
    run_burst(8'h08, M_READY, 2, 7, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
